serial_adder: RTL and testbench

- Bit-serial two's-complement adder: the inverse operation of the team's combinational 8-bit subtractor.
- Computes S = A + B, full width, no overflow: WIDTH+1 result bits, one bit per clock, LSB first.
- Serves as the sequential datapath exercise in the lab sequence, driven by a simple START/BUSY/DONE handshake.
- Result feeds the same self-checking exhaustive benches.

---
 rtl/serial_adder_pkg.sv | 20 ++
 rtl/serial_adder_full_adder.sv | 13 +
 rtl/serial_adder.sv | 101 ++++++++++
 tb/tb_serial_adder.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIN
  } state_e;

  localparam int unsigned DEFAULT_WIDTH = 8;

  // Bits needed to hold the values 0..v-1.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/serial_adder_full_adder.sv
// Combinational 1-bit full adder used by the serial adder datapath.
module serial_full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic cin_i,
  output logic s_o,
  output logic cout_o
);

  assign s_o    = a_i ^ b_i ^ cin_i;
  assign cout_o = (a_i & b_i) | (a_i & cin_i) | (b_i & cin_i);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial two's-complement adder, LSB first, WIDTH+1 result bits.
// Optional SUB port and subtraction mode enabled by SERIAL_ADDER_SUB_EN.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             SUB,
`endif
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH:0]   S
);

  localparam int unsigned CW = clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH);

  state_e           state_q;
  logic [WIDTH:0]   a_q, b_q;
  logic [WIDTH-1:0] sum_q;
  logic             carry_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH:0]   s_q;
  logic             done_q;

  logic             sub_d;
  logic [WIDTH:0]   a_d, b_d;
  logic             fa_s, fa_co;

`ifdef SERIAL_ADDER_SUB_EN
  assign sub_d = SUB;
`else
  assign sub_d = 1'b0;
`endif

  // Subtraction is A + ~B + 1: invert after sign extension, carry-in seeded with SUB.
  always_comb begin
    a_d = {A[WIDTH-1], A};
    b_d = {B[WIDTH-1], B} ^ {(WIDTH + 1){sub_d}};
  end

  serial_full_adder u_fa (
    .a_i    (a_q[0]),
    .b_i    (b_q[0]),
    .cin_i  (carry_q),
    .s_o    (fa_s),
    .cout_o (fa_co)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      s_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (START) begin
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= sub_d;
            cnt_q   <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          sum_q   <= {fa_s, sum_q[WIDTH-1:1]};
          a_q     <= {1'b0, a_q[WIDTH:1]};
          b_q     <= {1'b0, b_q[WIDTH:1]};
          carry_q <= fa_co;
          cnt_q   <= cnt_q + 1'b1;
          // Final bit goes straight into S; sum_q only ever holds the low WIDTH bits.
          if (cnt_q == LAST) begin
            s_q     <= {fa_s, sum_q};
            done_q  <= 1'b1;
            state_q <= FIN;
          end
        end
        FIN:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign BUSY = (state_q != IDLE);
  assign DONE = done_q;
  assign S    = s_q;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder with a cycle-level arithmetic reference model.
module tb_serial_adder;
  import serial_adder_pkg::*;

  localparam int unsigned W = DEFAULT_WIDTH;

  logic         CLK = 1'b0;
  logic         RST_N;
  logic         START;
  logic         SUB;
  logic [W-1:0] A, B;
  logic         BUSY, DONE;
  logic [W:0]   S;

  serial_adder #(.WIDTH(W)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .START (START),
    .A     (A),
    .B     (B),
`ifdef SERIAL_ADDER_SUB_EN
    .SUB   (SUB),
`endif
    .BUSY  (BUSY),
    .DONE  (DONE),
    .S     (S)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [W:0] s;
    int         due;
  } exp_t;

  exp_t       q[$];
  exp_t       e_mon;
  int         tests = 0;
  int         fails = 0;
  int         edge_cnt = 0;
  int         next_ok = 0;
  logic [W:0] held_s = '0;

  function automatic logic [W:0] ref_result(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic sub);
    int ai, bi, r;
    ai = int'($signed(a));
    bi = int'($signed(b));
    r  = sub ? ai - bi : ai + bi;
    return r[W:0];
  endfunction

  function automatic logic sub_eff();
`ifdef SERIAL_ADDER_SUB_EN
    return SUB;
`else
    return 1'b0;
`endif
  endfunction

  task automatic chk(input string name, input logic [W:0] act, input logic [W:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, edge_cnt);
    end
  endtask

  // Reference model: an operation is accepted whenever START is seen and the
  // previous operation's WIDTH+3 cycle slot has elapsed.
  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      q.delete();
      next_ok = 0;
    end else begin
      edge_cnt++;
      if (START && edge_cnt >= next_ok) begin
        exp_t e;
        e.s   = ref_result(A, B, sub_eff());
        e.due = edge_cnt + int'(W) + 1;
        q.push_back(e);
        next_ok = edge_cnt + int'(W) + 3;
      end
    end
  end

  // Monitor: compares BUSY every cycle, pops the scoreboard on DONE, checks S is held.
  always @(negedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      held_s = '0;
    end else begin
      chk("busy", {{W{1'b0}}, BUSY}, {{W{1'b0}}, (next_ok != 0) && (edge_cnt < next_ok - 1)});
      if (DONE) begin
        if (q.size() == 0) begin
          chk("spurious_done", {{W{1'b0}}, DONE}, '0);
        end else begin
          e_mon = q.pop_front();
          chk("sum", S, e_mon.s);
          chk("latency", (W+1)'(edge_cnt), (W+1)'(e_mon.due));
          held_s = e_mon.s;
        end
      end else if (q.size() > 0 && q[0].due <= edge_cnt) begin
        e_mon = q.pop_front();
        chk("missing_done", {{W{1'b0}}, DONE}, {{W{1'b0}}, 1'b1});
        held_s = e_mon.s;
      end
      chk("s_hold", S, held_s);
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while (BUSY && n < 100) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 100) begin
      tests++;
      fails++;
      $display("FAIL busy_timeout: BUSY still %b after %0d cycles, required 0", BUSY, n);
    end
  endtask

  task automatic op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
    wait_idle();
    A = a; B = b; SUB = sub; START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    A = W'($urandom); B = W'($urandom); SUB = 1'($urandom);
  endtask

  logic [W-1:0] corners[7] = '{8'h80, 8'h7F, 8'hFF, 8'h01, 8'h00, 8'hFE, 8'h81};

  initial begin
    RST_N = 1'b1; START = 1'b0; SUB = 1'b0; A = '0; B = '0;
    #2 RST_N = 1'b0;
    #1;
    chk("reset_busy", {{W{1'b0}}, BUSY}, '0);
    chk("reset_done", {{W{1'b0}}, DONE}, '0);
    chk("reset_s", S, '0);
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);

    op(8'h7F, 8'h7F, 1'b0);
    op(8'h80, 8'h80, 1'b0);
    op(8'hFF, 8'h01, 1'b0);
`ifdef SERIAL_ADDER_SUB_EN
    op(8'h80, 8'h7F, 1'b1);
    op(8'h7F, 8'h80, 1'b1);
`endif

    // START held high with operands changing every cycle.
    wait_idle();
    START = 1'b1;
    repeat (60) begin
      A = W'($urandom); B = W'($urandom); SUB = 1'($urandom);
      @(negedge CLK);
    end
    START = 1'b0;

    // Reset during the 4th RUN cycle.
    wait_idle();
    A = 8'h55; B = 8'h33; SUB = 1'b0; START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    repeat (3) @(negedge CLK);
    @(posedge CLK);
    #2 RST_N = 1'b0;
    #1;
    chk("abort_busy", {{W{1'b0}}, BUSY}, '0);
    chk("abort_done", {{W{1'b0}}, DONE}, '0);
    chk("abort_s", S, '0);
    @(negedge CLK);
    RST_N = 1'b1;
    repeat (12) @(negedge CLK);
    op(8'h12, 8'hF0, 1'b0);

    foreach (corners[i])
      foreach (corners[j]) begin
        op(corners[i], corners[j], 1'b0);
`ifdef SERIAL_ADDER_SUB_EN
        op(corners[i], corners[j], 1'b1);
`endif
      end

    repeat (1500) begin
      op(W'($urandom), W'($urandom), 1'($urandom));
      repeat ($urandom_range(0, 3)) @(negedge CLK);
    end

    wait_idle();
    repeat (3) @(negedge CLK);
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d results outstanding, required 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
